// File: rtl/everloop_pkg.sv
// everloop_pkg: shared frame-buffer constants and swap FSM state encoding
package everloop_pkg;
  localparam int EVERLOOP_N_BYTES = 141;
  localparam int EVERLOOP_ADDR_W  = 8;
  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} swap_state_e;
endpackage

// File: rtl/everloop_fb_bank.sv
// everloop_fb_bank: N_BYTES x 8 RAM, synchronous write, asynchronous read (out-of-range reads return 0)
module everloop_fb_bank
  import everloop_pkg::*;
#(
  parameter int N_BYTES = EVERLOOP_N_BYTES,
  parameter int ADDR_W  = EVERLOOP_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);
  logic [7:0] mem_q [N_BYTES];
  // write only in-range addresses; contents are never reset
  always_ff @(posedge clk) begin
    if (we_i && waddr_i < ADDR_W'(N_BYTES)) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = (raddr_i < ADDR_W'(N_BYTES)) ? mem_q[raddr_i] : 8'h00;
endmodule

// File: rtl/everloop_frame_buffer.sv
// everloop_frame_buffer: ping-pong LED frame store, swaps banks only in the driver's reset gap (optional EVERLOOP_FB_BRIGHTNESS_EN scaling)
module everloop_frame_buffer
  import everloop_pkg::*;
#(
  parameter int N_BYTES = EVERLOOP_N_BYTES,
  parameter int ADDR_W  = EVERLOOP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              commit,
  output logic              pending,
  output logic              swap_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic [7:0]        bright
);
  swap_state_e state_q;
  logic        sel_q, pending_q, swap_done_q;
  logic [7:0]  rdata0, rdata1, raw;
  logic        swap;
  everloop_fb_bank #(.N_BYTES(N_BYTES), .ADDR_W(ADDR_W)) u_bank0 (
    .clk(clk), .we_i(wr_en & sel_q), .waddr_i(wr_addr), .wdata_i(wr_data),
    .raddr_i(rd_addr), .rdata_o(rdata0)
  );
  everloop_fb_bank #(.N_BYTES(N_BYTES), .ADDR_W(ADDR_W)) u_bank1 (
    .clk(clk), .we_i(wr_en & ~sel_q), .waddr_i(wr_addr), .wdata_i(wr_data),
    .raddr_i(rd_addr), .rdata_o(rdata1)
  );
  assign swap = (state_q == ARMED) && (rd_addr == ADDR_W'(N_BYTES));
  // swap FSM: arm on commit, swap once the driver parks at the reset gap address
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      swap_done_q <= swap;
      if (swap) begin
        state_q   <= IDLE;
        sel_q     <= ~sel_q;
        pending_q <= 1'b0;
      end else if (state_q == IDLE && commit) begin
        state_q   <= ARMED;
        pending_q <= 1'b1;
      end
    end
  end
  assign pending   = pending_q;
  assign swap_done = swap_done_q;
  assign raw       = sel_q ? rdata1 : rdata0;
`ifdef EVERLOOP_FB_BRIGHTNESS_EN
  logic [15:0] scaled;
  assign scaled  = {8'h00, raw} * {7'h00, ({1'b0, bright} + 9'd1)};
  assign rd_data = scaled[15:8];
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign rd_data       = raw;
`endif
endmodule

// File: tb/tb_everloop_frame_buffer.sv
// tb_everloop_frame_buffer: directed scoreboard bench for the ping-pong frame buffer
module tb_everloop_frame_buffer;
  logic       clk = 1'b0;
  logic       rst, wr_en, commit, pending, swap_done;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data, bright;
  logic [7:0] exp_q[$];
  int         checks = 0, passes = 0, fails = 0;

  everloop_frame_buffer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .pending(pending), .swap_done(swap_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .bright(bright)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; wr_en = 1'b0; commit = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = 8'd5; bright = 8'hFF;
    step(); step();
    rst = 1'b0;
    expect_val(8'd0); chk("reset_pending", {7'd0, pending});
    expect_val(8'd0); chk("reset_swap_done", {7'd0, swap_done});
    // test 1: write back bank, commit, driver not in gap
    wr(8'd0, 8'h11);
    do_commit();
    expect_val(8'd1); chk("t1_pending", {7'd0, pending});
    step(); step(); step();
    expect_val(8'd1); chk("t1_pending_hold", {7'd0, pending});
    expect_val(8'd0); chk("t1_no_swap", {7'd0, swap_done});
    // test 2: driver reaches the gap, swap happens
    rd_addr = 8'd141;
    step();
    expect_val(8'd1); chk("t2_swap_done", {7'd0, swap_done});
    expect_val(8'd0); chk("t2_pending_clr", {7'd0, pending});
    expect_val(8'h00); chk("t2_gap_read", rd_data);
    rd_addr = 8'd0;
    #1;
    expect_val(8'h11); chk("t2_read_new", rd_data);
    step();
    expect_val(8'd0); chk("t2_pulse_one", {7'd0, swap_done});
    // test 3: out-of-range write ignored, out-of-range read is zero
    wr(8'd200, 8'hAA);
    rd_addr = 8'd200;
    #1;
    expect_val(8'h00); chk("t3_oor_front1", rd_data);
    // test 4: repeated commits while armed give one swap
    wr(8'd0, 8'h22);
    do_commit(); step(); do_commit(); step(); do_commit();
    expect_val(8'd1); chk("t4_pending", {7'd0, pending});
    rd_addr = 8'd141;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (swap_done) cnt++;
    end
    expect_val(8'd1); chk("t4_swap_count", cnt[7:0]);
    rd_addr = 8'd0;
    #1;
    expect_val(8'h22); chk("t4_sel_toggled_once", rd_data);
    rd_addr = 8'd200;
    #1;
    expect_val(8'h00); chk("t3_oor_front0", rd_data);
    // test 5: write in the swap cycle becomes visible
    do_commit();
    rd_addr = 8'd141;
    wr(8'd3, 8'h5C);
    expect_val(8'd1); chk("t5_swap_done", {7'd0, swap_done});
    rd_addr = 8'd3;
    #1;
    expect_val(8'h5C); chk("t5_swap_cycle_write", rd_data);
    rd_addr = 8'd0;
    #1;
    expect_val(8'h11); chk("t5_bank1_kept", rd_data);
    // reset mid-frame: pending lost, sel back to 0, RAM untouched
    do_commit();
    expect_val(8'd1); chk("rst_pending_before", {7'd0, pending});
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_val(8'd0); chk("rst_pending_lost", {7'd0, pending});
    rd_addr = 8'd141;
    step(); step();
    expect_val(8'd0); chk("rst_no_swap", {7'd0, swap_done});
    rd_addr = 8'd0;
    #1;
    expect_val(8'h22); chk("rst_ram_kept", rd_data);
    // write and commit in the same cycle
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 8'h77; commit = 1'b1;
    step();
    wr_en = 1'b0; commit = 1'b0;
    expect_val(8'd1); chk("wc_pending", {7'd0, pending});
    rd_addr = 8'd141;
    step();
    rd_addr = 8'd7;
    #1;
    expect_val(8'h77); chk("wc_read", rd_data);
    // test 6: brightness scaling of a full-scale byte
    wr(8'd9, 8'hFF);
    do_commit();
    rd_addr = 8'd141;
    step();
    rd_addr = 8'd9;
    bright = 8'h7F;
    #1;
`ifdef EVERLOOP_FB_BRIGHTNESS_EN
    expect_val(8'h7F); chk("t6_bright_7f", rd_data);
    bright = 8'hFF;
    #1;
    expect_val(8'hFF); chk("t6_bright_ff", rd_data);
    bright = 8'h00;
    #1;
    expect_val(8'h00); chk("t6_bright_00", rd_data);
`else
    expect_val(8'hFF); chk("t6_raw_7f", rd_data);
    bright = 8'h00;
    #1;
    expect_val(8'hFF); chk("t6_raw_00", rd_data);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
